if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 135 +++++++++++++
 tb/tb_if_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, one-outstanding imem request, 2-entry fetch buffer
module if_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        En_IF_ID,
   input  logic        Redirect,
   input  logic [31:0] RedirectPc,
   output logic        Imem_Req,
   output logic [31:0] Imem_Addr,
   input  logic        Imem_Gnt,
   input  logic        Imem_Rvalid,
   input  logic [31:0] Imem_Rdata,
   output logic [31:0] Instr_IF,
   output logic [31:0] Pc4_IF,
   output logic        Valid_IF
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] instr_mem_q [BUF_DEPTH];
   logic [31:0] instr_mem_d [BUF_DEPTH];
   logic [31:0] pc4_mem_q   [BUF_DEPTH];
   logic [31:0] pc4_mem_d   [BUF_DEPTH];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic        buf_valid;
   logic        gnt_fire;
   logic        push;
   logic        pop;

   assign buf_valid = (count_q != 2'd0);
   // Gating with the raw reset keeps the request low for the whole reset window.
   assign Imem_Req  = reset && (state_q == FETCH) && !count_q[1];
   assign Imem_Addr = pc_q;
   assign gnt_fire  = Imem_Req && Imem_Gnt;
   assign Valid_IF  = buf_valid;
   assign Instr_IF  = buf_valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;
   assign Pc4_IF    = buf_valid ? pc4_mem_q[rd_ptr_q]   : 32'h0000_0000;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      instr_mem_d = instr_mem_q;
      pc4_mem_d   = pc4_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      push        = 1'b0;
      pop         = 1'b0;

      if (Redirect) begin
         pc_d     = RedirectPc & 32'hFFFF_FFFC;
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         // A response landing in the same cycle as the redirect is itself the one
         // being discarded, so there is nothing left to drain.
         case (state_q)
            FETCH:   state_d = gnt_fire ? DRAIN : FETCH;
            WAIT:    state_d = Imem_Rvalid ? FETCH : DRAIN;
            DRAIN:   state_d = Imem_Rvalid ? FETCH : DRAIN;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (gnt_fire) begin
                  req_addr_d = pc_q;
                  pc_d       = pc_q + 32'd4;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (Imem_Rvalid) begin
                  push                  = 1'b1;
                  instr_mem_d[wr_ptr_q] = Imem_Rdata;
                  pc4_mem_d[wr_ptr_q]   = req_addr_q + 32'd4;
                  wr_ptr_d              = ~wr_ptr_q;
                  state_d               = FETCH;
               end
            end
            DRAIN: begin
               if (Imem_Rvalid) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase

         if (buf_valid && En_IF_ID) begin
            pop      = 1'b1;
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= 32'h0000_0000;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            instr_mem_q[i] <= 32'h0000_0000;
            pc4_mem_q[i]   <= 32'h0000_0000;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         instr_mem_q <= instr_mem_d;
         pc4_mem_q   <= pc4_mem_d;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed table-driven bench for if_fetch
module tb_if_fetch;

   logic        clk;
   logic        reset;
   logic        En_IF_ID;
   logic        Redirect;
   logic [31:0] RedirectPc;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Gnt;
   logic        Imem_Rvalid;
   logic [31:0] Imem_Rdata;
   logic [31:0] Instr_IF;
   logic [31:0] Pc4_IF;
   logic        Valid_IF;

   int n_checks;
   int n_fails;

   if_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .En_IF_ID   (En_IF_ID),
      .Redirect   (Redirect),
      .RedirectPc (RedirectPc),
      .Imem_Req   (Imem_Req),
      .Imem_Addr  (Imem_Addr),
      .Imem_Gnt   (Imem_Gnt),
      .Imem_Rvalid(Imem_Rvalid),
      .Imem_Rdata (Imem_Rdata),
      .Instr_IF   (Instr_IF),
      .Pc4_IF     (Pc4_IF),
      .Valid_IF   (Valid_IF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic        redir;
      logic [31:0] rpc;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc4;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rn, input logic en, input logic rd,
                               input logic [31:0] rpc, input logic g, input logic rv,
                               input logic [31:0] rdt, input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.rst_n = rn; v.en = en; v.redir = rd; v.rpc = rpc; v.gnt = g; v.rvalid = rv;
      v.rdata = rdt; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
      v.exp_instr = ei; v.exp_pc4 = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rn, input logic en, input logic rd, input logic [31:0] rpc,
                        input logic g, input logic rv, input logic [31:0] rdt);
      reset = rn; En_IF_ID = en; Redirect = rd; RedirectPc = rpc;
      Imem_Gnt = g; Imem_Rvalid = rv; Imem_Rdata = rdt;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      //             rn en rd rpc            g  rv rdata          req addr           v  instr          pc4
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_3000, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         1, 1, 32'h2408_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3004, 1, 32'h2408_0001, 32'h0000_3004));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3004, 0, 32'h0,         32'h0));
      // stall for six cycles with an always-granting memory
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_3000, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'hA000_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_3004, 1, 32'hA000_0001, 32'h0000_3004));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'hA000_0002, 0, 32'h0,         1, 32'hA000_0001, 32'h0000_3004));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hA000_0001, 32'h0000_3004));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hA000_0001, 32'h0000_3004));
      vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hA000_0001, 32'h0000_3004));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3008, 1, 32'hA000_0002, 32'h0000_3008));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_3008, 0, 32'h0,         32'h0));
      // redirect while waiting; stale response must vanish
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_3008, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h0000_4003, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'hDEAD_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_4000, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h1111_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_4004, 1, 32'h1111_0001, 32'h0000_4004));
      // redirect coincident with grant, with one entry buffered
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_4004, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h2222_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h0000_5000, 1, 0, 32'h0,         1, 32'h0000_4008, 1, 32'h2222_0001, 32'h0000_4008));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'hBAD0_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_5000, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h3333_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_5004, 1, 32'h3333_0001, 32'h0000_5004));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_5004, 0, 32'h0,         32'h0));
      // redirect in FETCH without grant
      vecs.push_back(mk(1, 0, 1, 32'h0000_6000, 0, 0, 32'h0,         1, 32'h0000_5004, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_6000, 0, 32'h0,         32'h0));
      // address wrap at the top of memory
      vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         1, 32'h0000_6000, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h4444_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h4444_0001, 32'h0000_0000));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0));
      // push and pop in the same cycle keep order
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h5555_0001, 0, 32'h0,         0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h5555_0001, 32'h0000_0004));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 1, 32'h5555_0002, 0, 32'h0,         1, 32'h5555_0001, 32'h0000_0004));
      vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h5555_0002, 32'h0000_0008));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h0,         32'h0));
      // response while in FETCH is ignored
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h6666_0001, 1, 32'h0000_0008, 0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h0,         32'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].redir, vecs[i].rpc,
               vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
         @(negedge clk);
         chk($sformatf("row%0d req", i), {31'h0, Imem_Req}, {31'h0, vecs[i].exp_req});
         if (vecs[i].exp_req)
            chk($sformatf("row%0d addr", i), Imem_Addr, vecs[i].exp_addr);
         chk($sformatf("row%0d valid", i), {31'h0, Valid_IF}, {31'h0, vecs[i].exp_valid});
         chk($sformatf("row%0d instr", i), Instr_IF, vecs[i].exp_instr);
         chk($sformatf("row%0d pc4", i), Pc4_IF, vecs[i].exp_pc4);
         @(posedge clk);
         #1;
      end

      // asynchronous reset between edges while a request is outstanding
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0001);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("pre_rst valid", {31'h0, Valid_IF}, 32'h1);
      chk("pre_rst instr", Instr_IF, 32'h7777_0001);
      @(posedge clk); #2;
      reset = 1'b0;
      Imem_Gnt = 1'b0;
      #1;
      chk("async_rst valid", {31'h0, Valid_IF}, 32'h0);
      chk("async_rst instr", Instr_IF, 32'h0);
      chk("async_rst pc4", Pc4_IF, 32'h0);
      chk("async_rst req", {31'h0, Imem_Req}, 32'h0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8888_0001);
      @(negedge clk);
      chk("post_rst req", {31'h0, Imem_Req}, 32'h1);
      chk("post_rst addr", Imem_Addr, 32'h0000_3000);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("post_rst rvalid ignored", {31'h0, Valid_IF}, 32'h0);
      chk("post_rst addr held", Imem_Addr, 32'h0000_3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
